// File: rtl/tron_pkg.sv
// tron_pkg: shared opcodes, condition codes, FSM states and flag bundle
// for the tron_core multicycle CPU.
package tron_pkg;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_MEM   = 4'h4;
    localparam logic [3:0] OP_ADDI  = 4'h5;
    localparam logic [3:0] OP_SUBI  = 4'h9;
    localparam logic [3:0] OP_CMPI  = 4'hB;
    localparam logic [3:0] OP_BR    = 4'hC;
    localparam logic [3:0] OP_MOVI  = 4'hD;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [3:0] EXT_LOAD = 4'h0;
    localparam logic [3:0] EXT_AND  = 4'h1;
    localparam logic [3:0] EXT_OR   = 4'h2;
    localparam logic [3:0] EXT_XOR  = 4'h3;
    localparam logic [3:0] EXT_STOR = 4'h4;
    localparam logic [3:0] EXT_ADD  = 4'h5;
    localparam logic [3:0] EXT_SUB  = 4'h9;
    localparam logic [3:0] EXT_CMP  = 4'hB;
    localparam logic [3:0] EXT_MOV  = 4'hD;

    localparam logic [3:0] COND_EQ  = 4'h0;
    localparam logic [3:0] COND_NE  = 4'h1;
    localparam logic [3:0] COND_LT  = 4'hC;
    localparam logic [3:0] COND_AL  = 4'hE;

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_ADD,
        ALU_SUB,
        ALU_MOV
    } alu_op_t;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
    } flags_t;

endpackage

// File: rtl/tron_alu.sv
// tron_alu: combinational ALU, result plus zero/negative/carry flags.
// Carry is carry-out on ADD and borrow on SUB.
module tron_alu
    import tron_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  alu_op_t           i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_res,
    output logic              o_z,
    output logic              o_n,
    output logic              o_c
);
    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_dif;

    assign w_sum = {1'b0, i_a} + {1'b0, i_b};
    assign w_dif = {1'b0, i_a} - {1'b0, i_b};

    always_comb begin
        o_res = i_b;
        o_c   = 1'b0;
        unique case (i_op)
            ALU_AND: o_res = i_a & i_b;
            ALU_OR:  o_res = i_a | i_b;
            ALU_XOR: o_res = i_a ^ i_b;
            ALU_ADD: begin
                o_res = w_sum[DATA_W-1:0];
                o_c   = w_sum[DATA_W];
            end
            ALU_SUB: begin
                o_res = w_dif[DATA_W-1:0];
                o_c   = w_dif[DATA_W];
            end
            default: o_res = i_b;
        endcase
    end

    assign o_z = (o_res == '0);
    assign o_n = o_res[DATA_W-1];

endmodule

// File: rtl/tron_core.sv
// tron_core: parametrised multicycle core (FETCH -> EXEC -> MEM) with one
// shared req/ack memory port for instructions and data.
module tron_core
    import tron_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int REG_COUNT = 16,
    parameter int ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] addressOut,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] busOutput,
    output logic              halted
);
    localparam int RIW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_pc;
    logic [15:0]       r_ir;
    flags_t            r_flags;
    logic [DATA_W-1:0] r_bus;
    logic [DATA_W-1:0] r_regs [REG_COUNT];

    logic [3:0]        w_op, w_rd, w_ext, w_rs, w_code;
    logic [DATA_W-1:0] w_rd_val, w_rs_val, w_imm, w_alu_b;
    logic [DATA_W-1:0] w_alu_res, w_wb_data;
    logic [ADDR_W-1:0] w_pc_next;
    alu_op_t           w_alu_op;
    logic              w_z, w_n, w_c;
    logic              w_arith, w_alu_wr, w_alu_flg, w_take;
    logic              w_is_load, w_is_store, w_is_halt;
    logic              w_hs, w_rd_ok, w_wb_en;

    assign w_op   = r_ir[15:12];
    assign w_rd   = r_ir[11:8];
    assign w_ext  = r_ir[7:4];
    assign w_rs   = r_ir[3:0];
    assign w_imm  = DATA_W'($signed(r_ir[7:0]));
    assign w_rd_ok  = int'(w_rd) < REG_COUNT;
    assign w_rd_val = w_rd_ok ? r_regs[w_rd[RIW-1:0]] : '0;
    assign w_rs_val = (int'(w_rs) < REG_COUNT) ? r_regs[w_rs[RIW-1:0]] : '0;

    assign w_is_load  = (w_op == OP_MEM) && (w_ext == EXT_LOAD);
    assign w_is_store = (w_op == OP_MEM) && (w_ext == EXT_STOR);
    assign w_is_halt  = (w_op == OP_HALT);
    assign w_arith = w_op inside {OP_RTYPE, OP_ADDI, OP_SUBI, OP_CMPI, OP_MOVI};
    // Immediate opcodes share the numeric codes of their R-type ext forms.
    assign w_code  = (w_op == OP_RTYPE) ? w_ext : w_op;
    assign w_alu_b = (w_op == OP_RTYPE) ? w_rs_val : w_imm;

    always_comb begin
        w_alu_op  = ALU_MOV;
        w_alu_wr  = 1'b0;
        w_alu_flg = 1'b0;
        if (w_arith) begin
            unique case (w_code)
                EXT_AND: begin w_alu_op = ALU_AND; w_alu_wr = 1'b1; end
                EXT_OR:  begin w_alu_op = ALU_OR;  w_alu_wr = 1'b1; end
                EXT_XOR: begin w_alu_op = ALU_XOR; w_alu_wr = 1'b1; end
                EXT_ADD: begin
                    w_alu_op  = ALU_ADD;
                    w_alu_wr  = 1'b1;
                    w_alu_flg = 1'b1;
                end
                EXT_SUB: begin
                    w_alu_op  = ALU_SUB;
                    w_alu_wr  = 1'b1;
                    w_alu_flg = 1'b1;
                end
                EXT_CMP: begin w_alu_op = ALU_SUB; w_alu_flg = 1'b1; end
                EXT_MOV: begin w_alu_op = ALU_MOV; w_alu_wr = 1'b1; end
                default: w_alu_op = ALU_MOV;
            endcase
        end
    end

    tron_alu #(.DATA_W(DATA_W)) u_alu (
        .i_op  (w_alu_op),
        .i_a   (w_rd_val),
        .i_b   (w_alu_b),
        .o_res (w_alu_res),
        .o_z   (w_z),
        .o_n   (w_n),
        .o_c   (w_c)
    );

    always_comb begin
        unique case (1'b1)
            (w_rd == COND_EQ): w_take = r_flags.z;
            (w_rd == COND_NE): w_take = !r_flags.z;
            (w_rd == COND_LT): w_take = r_flags.n;
            (w_rd == COND_AL): w_take = 1'b1;
            default:           w_take = 1'b0;
        endcase
    end

    assign w_pc_next = (w_op == OP_BR && w_take)
                     ? r_pc + ADDR_W'($signed(r_ir[7:0]))
                     : r_pc + ADDR_W'(1);

    // Gating with reset drops the request the moment reset asserts.
    assign mem_req    = reset && (r_state == S_FETCH || r_state == S_MEM);
    assign w_hs       = mem_req && mem_ack;
    assign mem_we     = (r_state == S_MEM) && w_is_store;
    assign addressOut = (r_state == S_MEM) ? ADDR_W'(w_rs_val) : r_pc;
    assign mem_wdata  = mem_we ? w_rd_val : '0;
    assign busOutput  = r_bus;
    assign halted     = (r_state == S_HALT);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_FETCH: if (w_hs) w_next = S_FETCH == S_FETCH ? S_EXEC : S_EXEC;
            S_EXEC: begin
                if (w_is_load || w_is_store) w_next = S_MEM;
                else if (w_is_halt)          w_next = S_HALT;
                else                         w_next = S_FETCH;
            end
            S_MEM:   if (w_hs) w_next = S_FETCH;
            S_HALT:  w_next = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    assign w_wb_data = (r_state == S_MEM) ? mem_rdata : w_alu_res;
    assign w_wb_en   = w_rd_ok
                     && (((r_state == S_EXEC) && w_alu_wr)
                     || ((r_state == S_MEM) && w_hs && w_is_load));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc    <= '0;
            r_ir    <= '0;
            r_flags <= '0;
            r_bus   <= '0;
            for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
        end else begin
            if (r_state == S_FETCH && w_hs)
                r_ir <= mem_rdata[15:0];
            if (r_state == S_EXEC && !w_is_load && !w_is_store && !w_is_halt)
                r_pc <= w_pc_next;
            if (r_state == S_MEM && w_hs)
                r_pc <= r_pc + ADDR_W'(1);
            if (r_state == S_EXEC && w_alu_flg)
                r_flags <= '{z: w_z, n: w_n, c: w_c};
            if (w_wb_en) begin
                r_regs[w_rd[RIW-1:0]] <= w_wb_data;
                r_bus                 <= w_wb_data;
            end
        end
    end

endmodule

// File: tb/tb_tron_core.sv
// tb_tron_core: directed programs plus random instruction streams checked
// every cycle against an instruction-level model of tron_core.
module tb_tron_core;
    localparam int DW = 16;
    localparam int RC = 8;
    localparam int AW = 16;
    localparam int P_FETCH = 0;
    localparam int P_EXEC  = 1;
    localparam int P_MEM   = 2;
    localparam int P_HALT  = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          mem_req, mem_we, mem_ack, halted;
    logic [AW-1:0] addressOut;
    logic [DW-1:0] mem_wdata, mem_rdata, busOutput;

    always #5 clk = ~clk;

    tron_core #(.DATA_W(DW), .REG_COUNT(RC), .ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .addressOut (addressOut),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .busOutput  (busOutput),
        .halted     (halted)
    );

    logic [15:0] mem [65536];
    int n_chk = 0;
    int n_fail = 0;

    logic [15:0] m_pc, m_ir, m_bus, m_addr, m_wdata, last_fetch;
    logic [15:0] m_reg [16];
    logic        m_z, m_n, m_c, m_we;
    int phase, wait_min, wait_max, wait_left, junk_ack;
    int fetch0_cnt, st_hold_cnt;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 25)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                         name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] rv(input logic [3:0] i);
        return (int'(i) < RC) ? m_reg[i] : 16'h0;
    endfunction

    task automatic wr(input logic [3:0] i, input logic [15:0] v);
        if (int'(i) < RC) begin
            m_reg[i] = v;
            m_bus    = v;
        end
    endtask

    // Architectural effect of one instruction held in m_ir.
    task automatic m_exec();
        logic [3:0]  op, rd, ext, rs, code;
        logic [15:0] a, b, imm;
        logic [16:0] t;
        logic        take;
        op  = m_ir[15:12];
        rd  = m_ir[11:8];
        ext = m_ir[7:4];
        rs  = m_ir[3:0];
        imm = {{8{m_ir[7]}}, m_ir[7:0]};
        a   = rv(rd);
        b   = (op == 4'h0) ? rv(rs) : imm;
        phase = P_FETCH;
        if (op == 4'h4 && (ext == 4'h0 || ext == 4'h4)) begin
            phase   = P_MEM;
            m_addr  = rv(rs);
            m_we    = (ext == 4'h4);
            m_wdata = a;
            return;
        end
        if (op == 4'hF) begin
            phase = P_HALT;
            return;
        end
        if (op == 4'hC) begin
            case (rd)
                4'h0:    take = m_z;
                4'h1:    take = !m_z;
                4'hC:    take = m_n;
                4'hE:    take = 1'b1;
                default: take = 1'b0;
            endcase
            m_pc = take ? m_pc + imm : m_pc + 16'd1;
            return;
        end
        if (op inside {4'h0, 4'h5, 4'h9, 4'hB, 4'hD}) begin
            code = (op == 4'h0) ? ext : op;
            case (code)
                4'h1: wr(rd, a & b);
                4'h2: wr(rd, a | b);
                4'h3: wr(rd, a ^ b);
                4'h5: begin
                    t = {1'b0, a} + {1'b0, b};
                    m_c = t[16];
                    m_z = (t[15:0] == 16'h0);
                    m_n = t[15];
                    wr(rd, t[15:0]);
                end
                4'h9, 4'hB: begin
                    t[15:0] = a - b;
                    m_c = (a < b);
                    m_z = (t[15:0] == 16'h0);
                    m_n = t[15];
                    if (code == 4'h9) wr(rd, t[15:0]);
                end
                4'hD: wr(rd, b);
                default: ;
            endcase
        end
        m_pc = m_pc + 16'd1;
    endtask

    task automatic step();
        logic hs;
        @(negedge clk);
        chk("halted", halted, phase == P_HALT);
        chk("busOutput", busOutput, m_bus);
        chk("flags", {dut.r_flags.z, dut.r_flags.n, dut.r_flags.c},
            {m_z, m_n, m_c});
        chk("mem_req", mem_req, phase == P_FETCH || phase == P_MEM);
        if (phase == P_FETCH) begin
            chk("fetch_addr", addressOut, m_pc);
            chk("fetch_we", mem_we, 1'b0);
        end else if (phase == P_MEM) begin
            chk("mem_addr", addressOut, m_addr);
            chk("mem_we", mem_we, m_we);
            if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
        end else begin
            chk("idle_we", mem_we, 1'b0);
        end
        if (mem_we && addressOut == 16'h0100) st_hold_cnt++;
        if (mem_req) begin
            if (wait_left == 0) mem_ack = 1'b1;
            else begin
                mem_ack = 1'b0;
                wait_left--;
            end
        end else begin
            mem_ack = (junk_ack != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        mem_rdata = mem[addressOut];
        hs = mem_req && mem_ack;
        if (hs) wait_left = $urandom_range(wait_min, wait_max);
        if (phase == P_FETCH && hs) begin
            last_fetch = addressOut;
            if (addressOut == 16'h0) fetch0_cnt++;
            m_ir  = mem[m_pc];
            phase = P_EXEC;
        end else if (phase == P_MEM && hs) begin
            if (m_we) mem[m_addr] = m_wdata;
            else      wr(m_ir[11:8], mem[m_addr]);
            m_pc  = m_pc + 16'd1;
            phase = P_FETCH;
        end else if (phase == P_EXEC) begin
            m_exec();
        end
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_addr", addressOut, 16'h0);
        chk("rst_wdata", mem_wdata, 16'h0);
        chk("rst_bus", busOutput, 16'h0);
        chk("rst_halted", halted, 1'b0);
        m_pc = 16'h0;
        m_bus = 16'h0;
        for (int i = 0; i < 16; i++) m_reg[i] = 16'h0;
        {m_z, m_n, m_c} = 3'b000;
        phase = P_FETCH;
        fetch0_cnt  = 0;
        st_hold_cnt = 0;
        last_fetch  = 16'hDEAD;
        wait_left = $urandom_range(wait_min, wait_max);
        reset = 1'b1;
    endtask

    task automatic run_to_halt(input int budget);
        int n;
        n = 0;
        while (phase != P_HALT && n < budget) begin
            step();
            n++;
        end
        chk("halt_reached", phase == P_HALT, 1'b1);
        repeat (10) step();
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
    endtask

    function automatic logic [15:0] rnd_insn();
        logic [3:0]  ops  [12];
        logic [3:0]  exts [8];
        logic [3:0]  conds [5];
        logic [15:0] w;
        ops   = '{4'h0, 4'h0, 4'h5, 4'h9, 4'hB, 4'hD,
                  4'h4, 4'h4, 4'hC, 4'hC, 4'h1, 4'h7};
        exts  = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD, 4'h6};
        conds = '{4'h0, 4'h1, 4'hC, 4'hE, 4'h3};
        w = 16'($urandom);
        w[15:12] = ops[$urandom_range(0, 11)];
        if (w[15:12] == 4'h0) w[7:4] = exts[$urandom_range(0, 7)];
        if (w[15:12] == 4'h4)
            w[7:4] = ($urandom_range(0, 3) == 0) ? 4'h2
                   : (($urandom_range(0, 1) == 1) ? 4'h4 : 4'h0);
        if (w[15:12] == 4'hC) w[11:8] = conds[$urandom_range(0, 4)];
        return w;
    endfunction

    initial begin
        mem_ack = 1'b0;
        mem_rdata = '0;
        junk_ack = 0;
        wait_min = 0;
        wait_max = 0;

        clear_mem();
        mem[0] = 16'hD105;
        mem[1] = 16'h51FF;
        mem[2] = 16'hF000;
        do_reset();
        run_to_halt(200);
        chk("A_bus", busOutput, 16'h0004);
        chk("A_model_r1", m_reg[1], 16'h0004);
        chk("A_model_c", m_c, 1'b1);
        chk("A_flag_c", dut.r_flags.c, 1'b1);
        chk("A_flag_z", dut.r_flags.z, 1'b0);

        junk_ack = 1;
        wait_max = 2;
        clear_mem();
        mem[16'h0000] = 16'hCE10;
        mem[16'h0010] = 16'hB200;
        mem[16'h0011] = 16'hC0FE;
        mem[16'h000F] = 16'hF000;
        do_reset();
        run_to_halt(300);
        chk("B_taken_pc", last_fetch, 16'h000F);

        clear_mem();
        mem[16'h0000] = 16'hD201;
        mem[16'h0001] = 16'hCE0F;
        mem[16'h0010] = 16'hB200;
        mem[16'h0011] = 16'hC0FE;
        mem[16'h0012] = 16'hF000;
        do_reset();
        run_to_halt(300);
        chk("B_fall_pc", last_fetch, 16'h0012);

        wait_min = 3;
        wait_max = 3;
        clear_mem();
        mem[0] = 16'hD440;
        mem[1] = 16'h0454;
        mem[2] = 16'h4304;
        mem[3] = 16'h0454;
        mem[4] = 16'h4344;
        mem[5] = 16'h4504;
        mem[6] = 16'hF000;
        mem[16'h0080] = 16'hBEEF;
        do_reset();
        run_to_halt(400);
        chk("C_mem100", mem[16'h0100], 16'hBEEF);
        chk("C_model_r5", m_reg[5], 16'hBEEF);
        chk("C_bus", busOutput, 16'hBEEF);
        chk("C_store_hold", st_hold_cnt, 4);

        wait_min = 0;
        wait_max = 1;
        clear_mem();
        mem[0] = 16'hD103;
        mem[1] = 16'hDC7F;
        mem[2] = 16'hF000;
        do_reset();
        run_to_halt(200);
        chk("D_dropped_bus", busOutput, 16'h0003);
        mem[2] = 16'h01DC;
        mem[3] = 16'hF000;
        do_reset();
        run_to_halt(200);
        chk("D_mov_oob_bus", busOutput, 16'h0000);

        clear_mem();
        mem[16'h0000] = 16'hC1FF;
        mem[16'hFFFF] = 16'hB000;
        mem[16'h0001] = 16'hF000;
        do_reset();
        run_to_halt(300);
        chk("E_fetch0_cnt", fetch0_cnt, 2);
        chk("E_last_fetch", last_fetch, 16'h0001);

        clear_mem();
        mem[0] = 16'hD105;
        mem[1] = 16'h51FF;
        mem[2] = 16'hF000;
        wait_min = 1000;
        wait_max = 1000;
        do_reset();
        repeat (3) step();
        #2 reset = 1'b0;
        #1 chk("F_req_async", mem_req, 1'b0);
        wait_min = 0;
        wait_max = 2;
        do_reset();
        run_to_halt(300);
        chk("F_bus", busOutput, 16'h0004);

        for (int r = 0; r < 2; r++) begin
            wait_min = 0;
            wait_max = (r == 0) ? 0 : 3;
            for (int i = 0; i < 65536; i++) mem[i] = rnd_insn();
            do_reset();
            repeat (4000) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
